// File: rtl/sec_ded_decoder_pipe.sv
// Two-stage extended-Hamming (SEC-DED) decoder with a valid/ready stream interface.
// Reports a 2-bit error class and the error position, and keeps saturating CE/UE counters.
module sec_ded_decoder_pipe #(
   parameter int DATA_W = 96,
   parameter int R      = 7,
   parameter int CNT_W  = 16,
   parameter int CW_W   = DATA_W + R + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   codeword_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        decode_result_out,
   output logic [7:0]        err_pos_out,
   output logic [CNT_W-1:0]  ce_cnt,
   output logic [CNT_W-1:0]  ue_cnt,
   input  logic              cnt_clr
);
   localparam int         MAX_POS   = DATA_W + R;
   localparam logic [1:0] RES_CLEAN = 2'b00;
   localparam logic [1:0] RES_CE    = 2'b01;
   localparam logic [1:0] RES_UE    = 2'b10;

   if ((2 ** R) < (DATA_W + R + 1)) begin : g_bad_r
      $error("sec_ded_decoder_pipe: 2**R must be >= DATA_W+R+1");
   end
   if (CW_W != DATA_W + R + 1) begin : g_bad_cw
      $error("sec_ded_decoder_pipe: CW_W is derived and must equal DATA_W+R+1");
   end

   // Hamming position (1-based) of data bit idx: the idx-th position that is not a power of two.
   function automatic int data_pos(input int idx);
      int pos;
      int cnt;
      pos = 0;
      cnt = -1;
      while (cnt < idx) begin
         pos = pos + 1;
         if ((pos & (pos - 1)) != 0) cnt = cnt + 1;
      end
      return pos;
   endfunction

   function automatic logic [DATA_W-1:0] cover_mask(input int j);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_W; i++) begin
         m[i] = (((data_pos(i) >> j) & 1) != 0);
      end
      return m;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic [DATA_W-1:0] w_data_in;
   logic [R-1:0]      w_chk_in;
   logic [R-1:0]      w_chk_calc;
   logic [R-1:0]      w_syn;
   logic              w_pe;
   logic              w_adv;
   logic              w_xfer;
   logic [DATA_W-1:0] w_flip;
   logic [DATA_W-1:0] w_data_fix;
   logic [1:0]        w_res;
   logic [7:0]        w_pos;

   logic              r_vld_p1;
   logic [DATA_W-1:0] r_data_p1;
   logic [R-1:0]      r_syn_p1;
   logic              r_pe_p1;
   logic              r_vld_p2;
   logic [DATA_W-1:0] r_data_p2;
   logic [1:0]        r_res_p2;
   logic [7:0]        r_pos_p2;
   logic [CNT_W-1:0]  r_ce_cnt;
   logic [CNT_W-1:0]  r_ue_cnt;

   assign w_data_in = codeword_in[DATA_W-1:0];
   assign w_chk_in  = codeword_in[DATA_W+R-1:DATA_W];

   for (genvar j = 0; j < R; j++) begin : g_chk
      localparam logic [DATA_W-1:0] MASK = cover_mask(j);
      assign w_chk_calc[j] = ^(w_data_in & MASK);
   end

   assign w_syn = w_chk_in ^ w_chk_calc;
   assign w_pe  = ^codeword_in;

   // The whole pipe moves as one; a stalled output freezes both stages.
   assign w_adv    = !r_vld_p2 || out_ready;
   assign in_ready = w_adv;
   assign w_xfer   = r_vld_p2 && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else if (w_adv) begin
         r_vld_p1 <= in_valid;
         r_vld_p2 <= r_vld_p1;
      end
   end

   // ---- stage 1: raw data, syndrome and overall parity ----
   always_ff @(posedge clk) begin
      if (w_adv && in_valid) begin
         r_data_p1 <= w_data_in;
         r_syn_p1  <= w_syn;
         r_pe_p1   <= w_pe;
      end
   end

   for (genvar g = 0; g < DATA_W; g++) begin : g_fix
      localparam int POS = data_pos(g);
      assign w_flip[g] = (r_syn_p1 == R'(POS));
   end

   // Syndromes beyond the last used position cannot come from a single flip.
   always_comb begin
      w_data_fix = r_data_p1;
      w_res      = RES_CLEAN;
      w_pos      = '0;
      if (r_pe_p1) begin
         if (int'(r_syn_p1) > MAX_POS) begin
            w_res = RES_UE;
         end else begin
            w_res      = RES_CE;
            w_pos      = 8'(r_syn_p1);
            w_data_fix = r_data_p1 ^ w_flip;
         end
      end else if (r_syn_p1 != '0) begin
         w_res = RES_UE;
      end
   end

   // ---- stage 2: corrected data, class and position ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_p2 <= '0;
         r_res_p2  <= RES_CLEAN;
         r_pos_p2  <= '0;
      end else if (w_adv && r_vld_p1) begin
         r_data_p2 <= w_data_fix;
         r_res_p2  <= w_res;
         r_pos_p2  <= w_pos;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_ce_cnt <= '0;
         r_ue_cnt <= '0;
      end else if (w_xfer) begin
         if (r_res_p2 == RES_CE) r_ce_cnt <= sat_inc(r_ce_cnt);
         if (r_res_p2 == RES_UE) r_ue_cnt <= sat_inc(r_ue_cnt);
      end
   end

   assign out_valid         = r_vld_p2;
   assign data_out          = r_data_p2;
   assign decode_result_out = r_res_p2;
   assign err_pos_out       = r_pos_p2;
   assign ce_cnt            = r_ce_cnt;
   assign ue_cnt            = r_ue_cnt;

endmodule

// File: tb/tb_sec_ded_decoder_pipe.sv
// Directed bench for sec_ded_decoder_pipe: vector table, streaming with stalls,
// counter saturation/clear on a CNT_W=2 instance, and mid-flight reset.
module tb_sec_ded_decoder_pipe;
   localparam int DW = 96;
   localparam int RB = 7;
   localparam int CW = 104;
   localparam int NB = 100;

   logic          clk = 1'b0;
   logic          rst;

   logic          in_valid, in_ready, out_valid, out_ready, cnt_clr;
   logic [CW-1:0] codeword_in;
   logic [DW-1:0] data_out;
   logic [1:0]    decode_result_out;
   logic [7:0]    err_pos_out;
   logic [15:0]   ce_cnt, ue_cnt;

   logic          in2_valid, in2_ready, out2_valid, out2_ready, cnt2_clr;
   logic [CW-1:0] cw2;
   logic [DW-1:0] data2;
   logic [1:0]    res2;
   logic [7:0]    pos2;
   logic [1:0]    ce2, ue2;

   sec_ded_decoder_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .decode_result_out(decode_result_out),
      .err_pos_out(err_pos_out), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .cnt_clr(cnt_clr)
   );

   sec_ded_decoder_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready),
      .codeword_in(cw2), .out_valid(out2_valid), .out_ready(out2_ready),
      .data_out(data2), .decode_result_out(res2),
      .err_pos_out(pos2), .ce_cnt(ce2), .ue_cnt(ue2), .cnt_clr(cnt2_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] cw;
      logic [DW-1:0] data;
      logic [1:0]    res;
      logic [7:0]    pos;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    res;
      logic [7:0]    pos;
   } exp_t;

   int n_cmp = 0;
   int n_bad = 0;
   int ce_e  = 0;
   int ue_e  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] b(input int k);
      return CW'(1) << k;
   endfunction

   // Check bits as XOR of the positions of all set data bits.
   function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
      logic [RB-1:0] p;
      int k;
      p = '0;
      k = 0;
      for (int pos = 1; pos <= DW + RB; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[k]) p = p ^ RB'(pos);
            k++;
         end
      end
      return {^{p, d}, p, d};
   endfunction

   function automatic int fpos(input int bitn);
      int k;
      if (bitn == CW - 1) return 0;
      if (bitn >= DW) return 1 << (bitn - DW);
      k = 0;
      for (int pos = 1; pos <= DW + RB; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (k == bitn) return pos;
            k++;
         end
      end
      return -1;
   endfunction

   task automatic run_vec(input string name, input vec_t v);
      int n;
      @(negedge clk);
      in_valid    = 1'b1;
      codeword_in = v.cw;
      out_ready   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk({name, "_early"}, 128'(out_valid), 128'(0));
      n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 128'(n), 128'(1));
      chk({name, "_data"}, 128'(data_out), 128'(v.data));
      chk({name, "_res"}, 128'(decode_result_out), 128'(v.res));
      chk({name, "_pos"}, 128'(err_pos_out), 128'(v.pos));
      if (v.res == 2'b01) ce_e++;
      if (v.res == 2'b10) ue_e++;
      @(negedge clk);
      chk({name, "_ce"}, 128'(ce_cnt), 128'(ce_e));
      chk({name, "_ue"}, 128'(ue_cnt), 128'(ue_e));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs [13];
      exp_t          q [$];
      exp_t          pend, e;
      logic [DW-1:0] d;
      logic [CW-1:0] cw;
      logic [DW-1:0] h_data;
      logic [1:0]    h_res;
      logic [7:0]    h_pos;
      int            sent, recv, cyc, stalls, n, seen, fb;
      logic          accepted, prev_stall, tog;

      vecs[0]  = '{'0, '0, 2'b00, 8'd0};
      vecs[1]  = '{b(103) | b(102), '0, 2'b10, 8'd0};
      vecs[2]  = '{b(0), '0, 2'b01, 8'd3};
      vecs[3]  = '{b(103), '0, 2'b01, 8'd0};
      vecs[4]  = '{b(96), '0, 2'b01, 8'd1};
      vecs[5]  = '{b(102), '0, 2'b01, 8'd64};
      vecs[6]  = '{b(0) | b(96) | b(97) | b(103), DW'(1), 2'b00, 8'd0};
      vecs[7]  = '{b(96) | b(97) | b(103), DW'(1), 2'b01, 8'd3};
      vecs[8]  = '{b(0) | b(1), DW'(3), 2'b10, 8'd0};
      vecs[9]  = '{b(96) | b(97) | b(98) | b(99) | b(100) | b(101) | b(102), '0, 2'b10, 8'd0};
      vecs[10] = '{b(95), '0, 2'b01, 8'd103};
      vecs[11] = '{b(4), '0, 2'b01, 8'd9};
      vecs[12] = '{b(96) | b(97), '0, 2'b10, 8'd0};

      rst = 1'b1;
      in_valid = 1'b0; codeword_in = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      in2_valid = 1'b0; cw2 = '0; out2_ready = 1'b1; cnt2_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_data", 128'(data_out), 128'(0));
      chk("rst_res", 128'(decode_result_out), 128'(0));
      chk("rst_pos", 128'(err_pos_out), 128'(0));
      chk("rst_ce", 128'(ce_cnt), 128'(0));
      chk("rst_ue", 128'(ue_cnt), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));

      for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Counter saturation and clear priority on the narrow-counter instance.
      @(negedge clk);
      in2_valid = 1'b1; cw2 = b(0); out2_ready = 1'b1;
      repeat (5) @(negedge clk);
      in2_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("sat_ce", 128'(ce2), 128'(3));
      chk("sat_ue", 128'(ue2), 128'(0));
      in2_valid = 1'b1; cw2 = b(5);
      @(negedge clk);
      in2_valid = 1'b0;
      n = 0;
      while (!out2_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("clr_wait", 128'(out2_valid), 128'(1));
      chk("clr_res", 128'(res2), 128'(2'b01));
      cnt2_clr = 1'b1;
      @(negedge clk);
      cnt2_clr = 1'b0;
      chk("clr_ce", 128'(ce2), 128'(0));
      chk("clr_drained", 128'(out2_valid), 128'(0));
      in2_valid = 1'b1; cw2 = b(7);
      @(negedge clk);
      in2_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("after_clr_ce", 128'(ce2), 128'(1));

      // Streaming: full rate for the first half, then out_ready toggling.
      sent = 0; recv = 0; cyc = 0; stalls = 0;
      accepted = 1'b0; prev_stall = 1'b0; tog = 1'b0;
      h_data = '0; h_res = '0; h_pos = '0;
      pend = '{'0, 2'b00, 8'd0};
      while (recv < NB && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (accepted) sent++;
         if (sent < NB) begin
            if (accepted || !in_valid) begin
               d = {$urandom, $urandom, $urandom};
               cw = encode(d);
               pend.data = d;
               if (sent % 2 == 0) begin
                  fb = int'($urandom_range(0, CW - 1));
                  cw[fb] = ~cw[fb];
                  pend.res = 2'b01;
                  pend.pos = 8'(fpos(fb));
               end else begin
                  pend.res = 2'b00;
                  pend.pos = 8'd0;
               end
               codeword_in = cw;
               in_valid = 1'b1;
            end
         end else begin
            in_valid = 1'b0;
         end
         if (sent < NB / 2) begin
            out_ready = 1'b1;
         end else begin
            out_ready = tog;
            tog = ~tog;
         end
         #1;
         if (prev_stall) begin
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_data", 128'(data_out), 128'(h_data));
            chk("stall_res", 128'(decode_result_out), 128'(h_res));
            chk("stall_pos", 128'(err_pos_out), 128'(h_pos));
            chk("stall_in_ready", 128'(in_ready), 128'(out_ready));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("stream_unexpected_beat", 128'(1), 128'(0));
            end else begin
               e = q.pop_front();
               chk($sformatf("stream%0d_data", recv), 128'(data_out), 128'(e.data));
               chk($sformatf("stream%0d_res", recv), 128'(decode_result_out), 128'(e.res));
               chk($sformatf("stream%0d_pos", recv), 128'(err_pos_out), 128'(e.pos));
            end
            recv++;
         end
         if (sent < NB / 2 && in_valid && !in_ready) stalls++;
         accepted = in_valid && in_ready;
         if (accepted) q.push_back(pend);
         prev_stall = out_valid && !out_ready;
         h_data = data_out;
         h_res  = decode_result_out;
         h_pos  = err_pos_out;
      end
      chk("stream_received", 128'(recv), 128'(NB));
      chk("stream_leftover", 128'(q.size()), 128'(0));
      chk("stream_full_rate_stalls", 128'(stalls), 128'(0));
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);

      // Reset with two beats in flight.
      in_valid = 1'b1; codeword_in = b(0);
      @(negedge clk);
      codeword_in = b(0) | b(1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("flight_present", 128'(out_valid), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_ce", 128'(ce_cnt), 128'(0));
      chk("mid_rst_ue", 128'(ue_cnt), 128'(0));
      chk("mid_rst_data", 128'(data_out), 128'(0));
      chk("mid_rst_res", 128'(decode_result_out), 128'(0));
      chk("mid_rst_pos", 128'(err_pos_out), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mid_rst_no_emerge", 128'(seen), 128'(0));
      chk("mid_rst_ce_after", 128'(ce_cnt), 128'(0));
      chk("mid_rst_ue_after", 128'(ue_cnt), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
